// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encoding and frame constants for the UART transmitter
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
   localparam int DATA_BITS = 8;
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running 0..DIV-1 counter with sync clear, tick on the last count of each bit
module baud_tick_gen #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   localparam int W = DIV > 1 ? $clog2(DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = cnt == W'(DIV - 1);
   always_ff @(posedge clk)
      cnt <= (rst || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_fifo_reader.sv
// uart_tx_fifo_reader: pops a show-ahead FIFO and sends each byte as 8N1 on tx; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_fifo_reader
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100_000_000,
   parameter int BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rdata,
   output logic       fifo_rd,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);
   localparam int DIV = CLK_FREQ / BAUD;
   localparam logic [2:0] LAST = 3'(DATA_BITS - 1);
   tx_state_e state, state_n;
   logic       tick, par, tx_n;
   logic [2:0] idx;
   logic [7:0] shift, shift_n;
`ifdef UART_TX_PARITY_EN
   localparam tx_state_e AFTER_DATA = PARITY;
   always_ff @(posedge clk)
      par <= rst ? 1'b0 : fifo_rd ? ^fifo_rdata : par;
`else
   localparam tx_state_e AFTER_DATA = STOP;
   assign par = 1'b1;
`endif
   baud_tick_gen #(.DIV(DIV)) u_baud (
      .clk (clk),
      .rst (rst),
      .clr (state == IDLE),
      .tick(tick)
   );
   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    state_n = fifo_empty ? IDLE : START;
         START:   state_n = tick ? DATA : START;
         DATA:    state_n = (tick && idx == LAST) ? AFTER_DATA : DATA;
         PARITY:  state_n = tick ? STOP : PARITY;
         STOP:    state_n = tick ? IDLE : STOP;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      fifo_rd = state == IDLE && !fifo_empty && !rst;
      tx_busy = state != IDLE;
   end
   // tx is registered from the next-state view so the line changes on the same edge as the state
   always_comb begin
      shift_n = fifo_rd ? fifo_rdata : (state == DATA && tick) ? shift >> 1 : shift;
      tx_n    = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : state_n == PARITY ? par : 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         tx      <= 1'b1;
         tx_done <= 1'b0;
         idx     <= '0;
         shift   <= '0;
      end else begin
         tx      <= tx_n;
         tx_done <= state == STOP && tick;
         idx     <= state != DATA ? '0 : (tick && idx != LAST) ? idx + 1'b1 : idx;
         shift   <= shift_n;
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// tb_uart_tx_fifo_reader: directed vectors for the FIFO-fed UART transmitter at DIV=10
module tb_uart_tx_fifo_reader;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       fifo_empty, fifo_rd, tx, tx_busy, tx_done;
   logic [7:0] fifo_rdata;
   logic [7:0] mem [0:15];
   logic [3:0] rp = '0, wp = '0;
   int checks = 0, errors = 0;
   logic tr_tx [0:349];
   logic tr_busy [0:349];
   logic tr_done [0:349];
   logic tr_rd [0:349];
`ifdef UART_TX_PARITY_EN
   localparam int DONE_OFF = 111;
   localparam logic BUSY_105 = 1'b1;
`else
   localparam int DONE_OFF = 101;
   localparam logic BUSY_105 = 1'b0;
`endif
   typedef struct {
      int   off;
      logic tx, busy, done, rd;
   } vec_t;
   vec_t vecs [0:18];

   uart_tx_fifo_reader #(.CLK_FREQ(1000), .BAUD(100)) dut (
      .clk       (clk),
      .rst       (rst),
      .fifo_empty(fifo_empty),
      .fifo_rdata(fifo_rdata),
      .fifo_rd   (fifo_rd),
      .tx        (tx),
      .tx_busy   (tx_busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;
   assign fifo_empty = rp == wp;
   assign fifo_rdata = mem[rp];
   always @(posedge clk) if (fifo_rd) rp <= rp + 1'b1;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] b);
      mem[wp] = b;
      wp = wp + 1'b1;
   endtask

   task automatic wait_rd(input string nm);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         found = fifo_rd;
      end
      chk({nm, "_pop_seen"}, 16'(found), 16'd1);
   endtask

   task automatic trace(input int n);
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         tr_tx[k] = tx; tr_busy[k] = tx_busy; tr_done[k] = tx_done; tr_rd[k] = fifo_rd;
      end
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int rds [$];
      int bad;
      logic [7:0] b;
      vecs = '{
         '{0,   1'b1, 1'b0, 1'b0, 1'b1}, '{1,   1'b0, 1'b1, 1'b0, 1'b0},
         '{10,  1'b0, 1'b1, 1'b0, 1'b0}, '{11,  1'b1, 1'b1, 1'b0, 1'b0},
         '{20,  1'b1, 1'b1, 1'b0, 1'b0}, '{21,  1'b0, 1'b1, 1'b0, 1'b0},
         '{35,  1'b1, 1'b1, 1'b0, 1'b0}, '{45,  1'b0, 1'b1, 1'b0, 1'b0},
         '{55,  1'b0, 1'b1, 1'b0, 1'b0}, '{65,  1'b1, 1'b1, 1'b0, 1'b0},
         '{75,  1'b0, 1'b1, 1'b0, 1'b0}, '{81,  1'b1, 1'b1, 1'b0, 1'b0},
         '{90,  1'b1, 1'b1, 1'b0, 1'b0}, '{91,  1'b1, 1'b1, 1'b0, 1'b0},
         '{95,  1'b1, 1'b1, 1'b0, 1'b0}, '{100, 1'b1, 1'b1, 1'b0, 1'b0},
         '{101, 1'b1, 1'b0, 1'b1, 1'b0}, '{102, 1'b1, 1'b0, 1'b0, 1'b0},
         '{110, 1'b1, 1'b0, 1'b0, 1'b0}
      };
      // reset held with a byte waiting: nothing may pop or toggle
      push(8'hA5);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk($sformatf("rst_rd%0d", i), 16'(fifo_rd), 16'd0);
         chk($sformatf("rst_tx%0d", i), 16'(tx), 16'd1);
         chk($sformatf("rst_busy%0d", i), 16'(tx_busy), 16'd0);
         chk($sformatf("rst_done%0d", i), 16'(tx_done), 16'd0);
      end
      @(posedge clk); #1 rst = 1'b0;
      // single frame 0xA5 against the vector table
      wait_rd("a5");
      trace(111);
      foreach (vecs[i]) begin
         chk($sformatf("a5_tx@%0d", vecs[i].off), 16'(tr_tx[vecs[i].off]), 16'(vecs[i].tx));
         chk($sformatf("a5_busy@%0d", vecs[i].off), 16'(tr_busy[vecs[i].off]), 16'(vecs[i].busy));
         chk($sformatf("a5_done@%0d", vecs[i].off), 16'(tr_done[vecs[i].off]), 16'(vecs[i].done));
         chk($sformatf("a5_rd@%0d", vecs[i].off), 16'(tr_rd[vecs[i].off]), 16'(vecs[i].rd));
      end
      bad = 0;
      for (int k = 0; k < 111; k++) bad += int'(tr_rd[k] && k != 0) + int'(tr_done[k] && k != 101);
      chk("a5_single_rd_done", 16'(bad), 16'd0);
      // back-to-back preloaded bytes
      @(posedge clk); #1 push(8'h00); push(8'hFF); push(8'h55);
      wait_rd("b2b");
      trace(330);
      for (int k = 0; k < 330; k++) if (tr_rd[k]) rds.push_back(k);
      chk("b2b_rd_count", 16'(rds.size()), 16'd3);
      if (rds.size() == 3) begin
         chk("b2b_rd1", 16'(rds[1]), 16'd101);
         chk("b2b_rd2", 16'(rds[2]), 16'd202);
         for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) b[i] = tr_tx[rds[f] + 15 + 10 * i];
            chk($sformatf("b2b_byte%0d", f), 16'(b), f == 0 ? 16'h00 : f == 1 ? 16'hFF : 16'h55);
         end
      end
      chk("b2b_done303", 16'(tr_done[303]), 16'd1);
      chk("b2b_empty", 16'(fifo_empty), 16'd1);
      // reset pulse in the middle of DATA
      @(posedge clk); #1 push(8'h3C);
      wait_rd("midrst");
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_tx", 16'(tx), 16'd1);
      chk("midrst_busy", 16'(tx_busy), 16'd0);
      rst = 1'b0;
      bad = 0;
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         bad += int'(tx_done) + int'(tx_busy) + int'(!tx);
      end
      chk("midrst_quiet", 16'(bad), 16'd0);
      // pop is blocked while rst is high even with data present
      rst = 1'b1; push(8'h81);
      @(negedge clk); chk("rstpop_rd0", 16'(fifo_rd), 16'd0);
      @(negedge clk); chk("rstpop_rd1", 16'(fifo_rd), 16'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk); chk("rstpop_rd_after", 16'(fifo_rd), 16'd1);
      repeat (110) @(negedge clk);
      // long empty stretch
      bad = 0;
      for (int k = 0; k < 500; k++) begin
         @(negedge clk);
         bad += int'(fifo_rd) + int'(!tx) + int'(tx_busy);
      end
      chk("empty_idle", 16'(bad), 16'd0);
      // parity build dependence: 0x07 has odd weight, parity bit 1
      @(posedge clk); #1 push(8'h07);
      wait_rd("par");
      trace(120);
      chk("par_tx95", 16'(tr_tx[95]), 16'd1);
      chk("par_busy105", 16'(tr_busy[105]), 16'(BUSY_105));
      chk("par_done", 16'(tr_done[DONE_OFF]), 16'd1);
      chk("par_done_early", 16'(tr_done[DONE_OFF - 1]), 16'd0);
      chk("par_bit2", 16'(tr_tx[35]), 16'd1);
      chk("par_bit3", 16'(tr_tx[45]), 16'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
